// File: rtl/led_channel_array.sv
// Multi-channel registered LED driver: per-channel mode/duty registers driven
// by a shared prescaler, PWM counter and blink phase.

module led_channel #(
    parameter int PWM_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [PWM_W+1:0] cfg_data,
    input  logic             val,
    input  logic             blink,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             led,
    output logic             led_nxt
);
    logic [1:0]       mode_q;
    logic [PWM_W-1:0] duty_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 2'd0;
            duty_q <= '0;
        end else if (we) begin
            mode_q <= cfg_data[PWM_W+1:PWM_W];
            duty_q <= cfg_data[PWM_W-1:0];
        end
    end

    // Full-scale duty is forced on so the channel never drops out at pwm_cnt max.
    always_comb begin
        led_nxt = 1'b0;
        unique case (mode_q)
            2'd0: led_nxt = 1'b0;
            2'd1: led_nxt = ~val;
            2'd2: led_nxt = val & blink;
            2'd3: led_nxt = val & ((duty_q == {PWM_W{1'b1}}) | (pwm_cnt < duty_q));
            default: led_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led <= 1'b0;
        else        led <= led_nxt;
    end
endmodule

module led_channel_array #(
    parameter int CH    = 4,
    parameter int PWM_W = 4,
    parameter int DIV   = 16,
    parameter int AW    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CH-1:0]    val,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [PWM_W+1:0] cfg_data,
    output logic [CH-1:0]    led,
    output logic             led_all,
    output logic             tick
);
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic [PWM_W-1:0] pwm_cnt;
    logic             blink_q;
    logic             pre_wrap;
    logic             addr_ok;
    logic [CH-1:0]    we_vec;
    logic [CH-1:0]    led_nxt;

    assign pre_wrap = (pre_cnt == PRE_MAX);
    assign addr_ok  = (32'(cfg_addr) < CH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
            blink_q <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick    <= pre_wrap;
            pre_cnt <= pre_wrap ? '0 : pre_cnt + 1'b1;
            if (pre_wrap) begin
                pwm_cnt <= pwm_cnt + 1'b1;
                if (pwm_cnt == {PWM_W{1'b1}}) blink_q <= ~blink_q;
            end
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        assign we_vec[i] = cfg_we & addr_ok & (cfg_addr == AW'(i));
        led_channel #(.PWM_W(PWM_W)) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .we       (we_vec[i]),
            .cfg_data (cfg_data),
            .val      (val[i]),
            .blink    (blink_q),
            .pwm_cnt  (pwm_cnt),
            .led      (led[i]),
            .led_nxt  (led_nxt[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led_all <= 1'b0;
        else        led_all <= &led_nxt;
    end
endmodule

// File: tb/tb_led_channel_array.sv
// Randomized bench for led_channel_array against a time-based reference model
// (counter state derived from edges since reset release).

module tb_led_channel_array;
    localparam int DIV = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] val;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [5:0] cfg_data;
    logic [3:0] led;
    logic       led_all;
    logic       tick;

    logic [2:0] val3;
    logic       cfg_we3;
    logic [1:0] cfg_addr3;
    logic [5:0] cfg_data3;
    logic [2:0] led3;
    logic       led_all3;
    logic       tick3;

    int checks = 0;
    int fails  = 0;
    int n      = 0;

    logic [1:0] m_mode [4];
    logic [3:0] m_duty [4];
    logic [1:0] m3_mode[3];
    logic [3:0] m3_duty[3];
    logic [3:0] exp_led;
    logic [2:0] exp_led3;
    logic       exp_all, exp_all3, exp_tick;

    led_channel_array #(.CH(4), .PWM_W(4), .DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .val(val), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .led(led), .led_all(led_all), .tick(tick)
    );

    led_channel_array #(.CH(3), .PWM_W(4), .DIV(DIV)) dut3 (
        .clk(clk), .rst_n(rst_n), .val(val3), .cfg_we(cfg_we3), .cfg_addr(cfg_addr3),
        .cfg_data(cfg_data3), .led(led3), .led_all(led_all3), .tick(tick3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // nn = clock edges since reset release before the edge being predicted.
    function automatic logic model_led(input logic [1:0] md, input logic [3:0] dt,
                                       input logic v, input int nn);
        int pw, bl;
        pw = (nn / DIV) % 16;
        bl = (nn / (DIV * 16)) % 2;
        case (md)
            2'd1:    return !v;
            2'd2:    return v && (bl == 1);
            2'd3:    return v && ((dt == 4'hF) || (pw < int'(dt)));
            default: return 1'b0;
        endcase
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin m_mode[i] = 0; m_duty[i] = 0; end
        for (int i = 0; i < 3; i++) begin m3_mode[i] = 0; m3_duty[i] = 0; end
    endtask

    task automatic step();
        logic in_rst;
        in_rst = !rst_n;
        if (in_rst) begin
            exp_led = 0; exp_led3 = 0; exp_tick = 0;
            clear_model();
        end else begin
            for (int i = 0; i < 4; i++) exp_led[i]  = model_led(m_mode[i],  m_duty[i],  val[i],  n);
            for (int i = 0; i < 3; i++) exp_led3[i] = model_led(m3_mode[i], m3_duty[i], val3[i], n);
            exp_tick = ((n + 1) % DIV) == 0;
            if (cfg_we) begin
                m_mode[cfg_addr] = cfg_data[5:4];
                m_duty[cfg_addr] = cfg_data[3:0];
            end
            if (cfg_we3 && int'(cfg_addr3) < 3) begin
                m3_mode[cfg_addr3] = cfg_data3[5:4];
                m3_duty[cfg_addr3] = cfg_data3[3:0];
            end
        end
        exp_all  = &exp_led;
        exp_all3 = &exp_led3;
        @(posedge clk); #1;
        if (in_rst) n = 0; else n++;
    endtask

    task automatic write_cfg(input logic [1:0] a, input logic [1:0] md, input logic [3:0] dt);
        cfg_we = 1; cfg_addr = a; cfg_data = {md, dt};
        step();
        cfg_we = 0;
    endtask

    task automatic write3(input logic [1:0] a, input logic [1:0] md, input logic [3:0] dt);
        cfg_we3 = 1; cfg_addr3 = a; cfg_data3 = {md, dt};
        step();
        cfg_we3 = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; val = 0; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
        val3 = 0; cfg_we3 = 0; cfg_addr3 = 0; cfg_data3 = 0;
        clear_model();
        #1;
        checks++; if (led !== 4'b0)   begin fails++; $display("FAIL reset_led got=%b exp=0", led); end
        checks++; if (led_all !== 0)  begin fails++; $display("FAIL reset_led_all got=%b exp=0", led_all); end
        checks++; if (tick !== 0)     begin fails++; $display("FAIL reset_tick got=%b exp=0", tick); end
        step(); step();
        rst_n = 1;
        for (int c = 0; c < 8; c++) begin
            val = 4'($urandom);
            step();
            checks++; if (led !== 4'b0) begin fails++; $display("FAIL off_after_reset c=%0d got=%b exp=0000", c, led); end
        end
    endtask

    task automatic test_inv();
        for (int i = 0; i < 4; i++) write_cfg(2'(i), 2'd1, 4'd0);
        val = 4'b0101;
        step();
        checks++; if (led !== 4'b1010) begin fails++; $display("FAIL inv_0101 got=%b exp=1010", led); end
        checks++; if (led_all !== 0)   begin fails++; $display("FAIL inv_all_low got=%b exp=0", led_all); end
        val = 4'b0000;
        step();
        checks++; if (led_all !== 1)   begin fails++; $display("FAIL inv_all_high got=%b exp=1", led_all); end
        for (int c = 0; c < 16; c++) begin
            val = 4'($urandom);
            step();
            checks++; if (led !== exp_led || led_all !== exp_all)
                begin fails++; $display("FAIL inv_rand c=%0d got=%b/%b exp=%b/%b", c, led, led_all, exp_led, exp_all); end
        end
    endtask

    task automatic test_latency();
        write_cfg(2'd0, 2'd0, 4'd0);
        val = 4'b0000;
        step();
        write_cfg(2'd0, 2'd1, 4'd0);
        checks++; if (led[0] !== 0) begin fails++; $display("FAIL latency_edge_k got=%b exp=0", led[0]); end
        step();
        checks++; if (led[0] !== 1) begin fails++; $display("FAIL latency_edge_k1 got=%b exp=1", led[0]); end
    endtask

    task automatic pwm_window(input logic [3:0] dt, input int cycles, input int exp_hi);
        int hi;
        hi = 0;
        write_cfg(2'd2, 2'd3, dt);
        step();
        for (int c = 0; c < cycles; c++) begin
            step();
            if (led[2]) hi++;
            checks++; if (led !== exp_led)
                begin fails++; $display("FAIL pwm_model duty=%0d c=%0d got=%b exp=%b", dt, c, led, exp_led); end
        end
        checks++; if (hi !== exp_hi) begin fails++; $display("FAIL pwm_count duty=%0d got=%0d exp=%0d", dt, hi, exp_hi); end
    endtask

    task automatic test_pwm();
        logic [3:0] d;
        val = 4'b0100;
        pwm_window(4'd4, 128, 32);
        pwm_window(4'd0, 64, 0);
        pwm_window(4'd15, 64, 64);
        for (int r = 0; r < 3; r++) begin
            d = 4'($urandom_range(1, 14));
            pwm_window(d, 64, int'(d) * DIV);
        end
    endtask

    task automatic test_blink();
        int last_t, ticks, t_cnt;
        logic prev;
        val = 4'b0010;
        write_cfg(2'd1, 2'd2, 4'd0);
        step();
        prev = led[1]; last_t = -1; ticks = 0; t_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (c < 64 && tick) ticks++;
            checks++; if (led !== exp_led || tick !== exp_tick)
                begin fails++; $display("FAIL blink_model c=%0d got=%b/%b exp=%b/%b", c, led, tick, exp_led, exp_tick); end
            if (led[1] !== prev) begin
                if (last_t >= 0) begin
                    t_cnt++;
                    checks++; if (c - last_t !== 64)
                        begin fails++; $display("FAIL blink_period got=%0d exp=64", c - last_t); end
                end
                last_t = c;
            end
            prev = led[1];
        end
        checks++; if (ticks !== 16) begin fails++; $display("FAIL tick_rate got=%0d exp=16", ticks); end
        checks++; if (t_cnt < 2)    begin fails++; $display("FAIL blink_toggles got=%0d exp>=2", t_cnt); end
    endtask

    task automatic test_back_to_back();
        val = 4'b0000;
        write_cfg(2'd3, 2'd1, 4'd0);
        write_cfg(2'd3, 2'd0, 4'd0);
        step(); step();
        checks++; if (led[3] !== 0) begin fails++; $display("FAIL b2b_last_wins got=%b exp=0", led[3]); end
        cfg_we = 1; cfg_addr = 2'd3; cfg_data = {2'd0, 4'd0}; step();
        cfg_data = {2'd1, 4'd0}; step();
        cfg_we = 0; step();
        checks++; if (led[3] !== 1) begin fails++; $display("FAIL b2b_last_wins2 got=%b exp=1", led[3]); end
    endtask

    task automatic test_addr_filter();
        write3(2'd1, 2'd1, 4'd0);
        write3(2'd2, 2'd1, 4'd0);
        for (int c = 0; c < 8; c++) begin
            val3 = 3'($urandom);
            cfg_we3 = 1; cfg_addr3 = 2'd3; cfg_data3 = {2'($urandom), 4'($urandom)};
            step();
            checks++; if (led3 !== exp_led3 || led_all3 !== exp_all3)
                begin fails++; $display("FAIL addr_ignored c=%0d got=%b/%b exp=%b/%b", c, led3, led_all3, exp_led3, exp_all3); end
        end
        cfg_we3 = 0;
        val3 = 3'b000; step(); step();
        checks++; if (led3 !== 3'b110) begin fails++; $display("FAIL addr_no_change got=%b exp=110", led3); end
        for (int c = 0; c < 16; c++) begin
            val3 = 3'($urandom);
            cfg_we3 = 1; cfg_addr3 = 2'd0; cfg_data3 = {2'($urandom), 4'($urandom)};
            step();
            checks++; if (led3 !== exp_led3 || led3[2:1] !== ~val3[2:1] && 0)
                begin fails++; $display("FAIL ch0_writes c=%0d got=%b exp=%b", c, led3, exp_led3); end
            checks++; if (led3[2:1] !== ~val3[2:1])
                begin fails++; $display("FAIL ch12_undisturbed c=%0d got=%b exp=%b", c, led3[2:1], ~val3[2:1]); end
        end
        cfg_we3 = 0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) write_cfg(2'(i), 2'd1, 4'd0);
        val = 4'b0000;
        step(); step();
        checks++; if (led !== 4'b1111) begin fails++; $display("FAIL pre_reset_on got=%b exp=1111", led); end
        #2 rst_n = 0;
        #1;
        checks++; if (led !== 4'b0 || led_all !== 0 || tick !== 0)
            begin fails++; $display("FAIL async_reset got=%b/%b/%b exp=0000/0/0", led, led_all, tick); end
        cfg_we = 1; cfg_addr = 2'd0; cfg_data = {2'd1, 4'd0};
        step();
        cfg_we = 0;
        rst_n = 1;
        for (int c = 0; c < 8; c++) begin
            val = (c < 4) ? 4'b0000 : 4'($urandom);
            step();
            checks++; if (led !== 4'b0 || tick !== exp_tick)
                begin fails++; $display("FAIL write_lost_in_reset c=%0d got=%b/%b exp=0000/%b", c, led, tick, exp_tick); end
        end
    endtask

    initial begin
        test_reset();
        test_inv();
        test_latency();
        test_pwm();
        test_blink();
        test_back_to_back();
        test_addr_filter();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
